przerwania_ctrl: RTL
====================

Name: przerwania_ctrl

Overview:
- Interrupt controller downstream of the timer and other peripherals; consumes their single-cycle interrupt pulses (e.g. the timer's interrupt output).
- Latches each pulse into a pending register and applies a per-source mask and a global enable.
- Selects the highest-priority request and presents it to the CPU core as a level request plus vector, using an ack/return handshake.
- Written from the CPU data bus with the same 8-bit value + write-strobe scheme as other peripherals.

Parameters:
N_SRC, 4, number of interrupt sources; legal range 1..8; source 0 has highest priority
VW, 3, vector width; must satisfy 2**VW >= N_SRC

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
irq_src  input  N_SRC  per-source interrupt pulses; bit i high for one or more cycles = event(s) on source i
wartosc  input  8  CPU write data
zapisz_mask  input  1  write strobe: mask <= wartosc[N_SRC-1:0]
zapisz_ctr  input  1  write strobe: gie <= wartosc[7]
zapisz_clr  input  1  write strobe: pending <= pending & ~wartosc[N_SRC-1:0]
cpu_ack  input  1  CPU accepts current request (one-cycle pulse)
cpu_reti  input  1  CPU finished handler (one-cycle pulse)
cpu_irq  output  1  registered interrupt request to CPU
cpu_vector  output  VW  index of requested/in-service source; stable while cpu_irq=1 and in SERVICE
pending  output  N_SRC  pending register, readable status
in_service  output  1  high while a handler is active

Behaviour:
- Reset: pending=0, mask=0, gie=0, state=IDLE, cpu_irq=0, cpu_vector=0, in_service=0. Reset mid-request or mid-handler aborts everything to these values on the next edge.
- Pending latch:
  - Every cycle, pending[i] <= 1 if irq_src[i]=1, independent of mask, gie and state.
  - Set beats clear: a simultaneous pulse and clear (zapisz_clr, or an ack clear) leaves the bit at 1.
  - Multiple pulses while pending are merged; there is no count.
- Register writes:
  - Strobes are independent; several may be active in one cycle.
  - Bits of wartosc above N_SRC-1 are ignored for mask and clr.
- Request vector: req = pending & mask. Priority encoder selects the lowest index set.
- FSM states IDLE, REQ, SERVICE.
  - IDLE: if gie && |req, at the next edge go to REQ with cpu_irq=1 and cpu_vector=encoded index (latched). Otherwise stay; cpu_irq=0.
  - REQ:
    - cpu_vector is frozen; a later higher-priority arrival does not change it.
    - If cpu_ack=1: clear pending[cpu_vector] (subject to set-beats-clear), then cpu_irq<=0, in_service<=1, go to SERVICE.
    - Else if gie=0 or req[cpu_vector]=0 (masked/cleared by software): withdraw, cpu_irq<=0, go to IDLE. The withdrawal check uses the current-cycle register values, before any same-cycle write.
    - cpu_ack takes precedence over withdrawal and over cpu_reti in the same cycle.
  - SERVICE:
    - No nesting; new requests only accumulate in pending.
    - cpu_vector holds the serviced index.
    - cpu_reti=1: in_service<=0, go to IDLE.
    - cpu_ack is ignored.
- cpu_ack in IDLE, and cpu_reti in IDLE/REQ, are ignored.
- Latency:
  - Pulse sampled at edge t: pending visible after t; cpu_irq high after edge t+1.
  - After reti at edge r with another request pending: IDLE for one cycle, cpu_irq high after edge r+1.
- No combinational path from any input to cpu_irq or cpu_vector.

Test Plan:
1. Reset, mask=0x01, gie=1, one-cycle pulse irq_src=0001 -> pending=0001 next cycle, cpu_irq=1 one cycle later, vector=0; ack -> pending=0000, in_service=1, cpu_irq=0; reti -> in_service=0, IDLE.
2. mask=0x0F, gie=1, irq_src=1010 same cycle -> vector=1; ack/reti -> pending=1000, then second request vector=3 appears one cycle after reti.
3. mask=0x00, pulse source 2 -> pending=0100, cpu_irq stays 0; write mask=0x04 -> cpu_irq=1 two cycles after the write strobe, vector=2.
4. In REQ with vector=2, pulse source 0 -> vector stays 2; same-cycle ack and new source-2 pulse -> pending[2] stays 1 and re-requests after reti.
5. In REQ, write gie=0 (or zapisz_clr with bit of vector) -> cpu_irq drops next cycle, state IDLE, no in_service; gie=1 again -> request reissued only if still pending.
6. rst asserted in SERVICE with pending=0110 -> all outputs 0, pending=0, mask=0 next cycle; a stray cpu_reti/cpu_ack in IDLE -> no change.

Source files
------------

// File: rtl/przerwania_ctrl_if.sv
// CPU-side bundle of the interrupt controller: peripheral pulses, register
// write port and the request/ack/reti handshake with the core.
interface przerwania_ctrl_if #(
    parameter int N_SRC = 4,
    parameter int VW    = 3
);
    logic [N_SRC-1:0] irq_src;
    logic [7:0]       wartosc;
    logic             zapisz_mask;
    logic             zapisz_ctr;
    logic             zapisz_clr;
    logic             cpu_ack;
    logic             cpu_reti;
    logic             cpu_irq;
    logic [VW-1:0]    cpu_vector;
    logic [N_SRC-1:0] pending;
    logic             in_service;

    modport master (
        output irq_src, wartosc, zapisz_mask, zapisz_ctr, zapisz_clr,
        output cpu_ack, cpu_reti,
        input  cpu_irq, cpu_vector, pending, in_service
    );

    modport slave (
        input  irq_src, wartosc, zapisz_mask, zapisz_ctr, zapisz_clr,
        input  cpu_ack, cpu_reti,
        output cpu_irq, cpu_vector, pending, in_service
    );
endinterface

// File: rtl/przerwania_ctrl.sv
// Interrupt controller: latches peripheral pulses, masks them, and hands the
// highest-priority source (lowest index) to the CPU with an ack/reti handshake.
module przerwania_ctrl #(
    parameter int N_SRC = 4,
    parameter int VW    = 3
) (
    input logic             clk,
    input logic             rst,
    przerwania_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_r;
    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] mask_r;
    logic             gie_r;
    logic             cpu_irq_r;
    logic [VW-1:0]    vector_r;
    logic             in_service_r;

    logic [N_SRC-1:0] req_s;
    logic [N_SRC-1:0] vec_onehot_s;
    logic             req_sel_s;
    logic [N_SRC-1:0] clr_wr_s;
    logic [N_SRC-1:0] clr_ack_s;
    logic [N_SRC-1:0] pending_nxt_s;

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic logic [VW-1:0] prio_enc(input logic [N_SRC-1:0] r);
        logic [VW-1:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (r[i]) begin
                idx = VW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Request vector, selected-source test and next pending value (set beats clear).
    always_comb begin
        vec_onehot_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            vec_onehot_s[i] = (vector_r == VW'(i));
        end
        req_s     = pending_r & mask_r;
        req_sel_s = |(req_s & vec_onehot_s);
        if (bus.zapisz_clr) begin
            clr_wr_s = bus.wartosc[N_SRC-1:0];
        end else begin
            clr_wr_s = '0;
        end
        if ((state_r == REQ) && bus.cpu_ack) begin
            clr_ack_s = vec_onehot_s;
        end else begin
            clr_ack_s = '0;
        end
        pending_nxt_s = (pending_r & ~(clr_wr_s | clr_ack_s)) | bus.irq_src;
    end

    // Software-visible registers: pending, mask and global enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
            mask_r    <= '0;
            gie_r     <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            if (bus.zapisz_mask) begin
                mask_r <= bus.wartosc[N_SRC-1:0];
            end
            if (bus.zapisz_ctr) begin
                gie_r <= bus.wartosc[7];
            end
        end
    end

    // Request/service handshake FSM with registered CPU-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cpu_irq_r    <= 1'b0;
            vector_r     <= '0;
            in_service_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gie_r && (|req_s)) begin
                        state_r   <= REQ;
                        cpu_irq_r <= 1'b1;
                        vector_r  <= prio_enc(req_s);
                    end else begin
                        cpu_irq_r <= 1'b0;
                    end
                end
                REQ: begin
                    // Ack wins over withdrawal; withdrawal sees pre-write register values.
                    if (bus.cpu_ack) begin
                        state_r      <= SERVICE;
                        cpu_irq_r    <= 1'b0;
                        in_service_r <= 1'b1;
                    end else if (!gie_r || !req_sel_s) begin
                        state_r   <= IDLE;
                        cpu_irq_r <= 1'b0;
                    end else begin
                        cpu_irq_r <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (bus.cpu_reti) begin
                        state_r      <= IDLE;
                        in_service_r <= 1'b0;
                    end else begin
                        in_service_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cpu_irq_r    <= 1'b0;
                    in_service_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_irq    = cpu_irq_r;
    assign bus.cpu_vector = vector_r;
    assign bus.pending    = pending_r;
    assign bus.in_service = in_service_r;

endmodule
